// File: rtl/ccd_pip_pkg.sv
// ccd_pip_pkg: shared widths and pixel type for the CCD picture-in-picture path
package ccd_pip_pkg;
    localparam int CCD_DW    = 10;
    localparam int CCD_IN_W  = 1280;
    localparam int PIP_OUT_W = 320;

    typedef struct packed {
        logic [CCD_DW-1:0] r;
        logic [CCD_DW-1:0] g;
        logic [CCD_DW-1:0] b;
    } rgb_t;
endpackage

// File: rtl/decim_acc.sv
// decim_acc: one colour channel of the 4:1 box average, output registered on the last phase
module decim_acc
    import ccd_pip_pkg::*;
#(
    parameter int DW = CCD_DW,
    parameter int SH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          load,
    input  logic [SH-1:0] phase,
    input  logic [DW-1:0] pixIn,
    output logic [DW-1:0] pixOut
);
    logic [DW+SH-1:0] acc;
    logic [DW+SH-1:0] sum;

    assign sum = acc + (DW+SH)'(pixIn);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            acc    <= '0;
            pixOut <= '0;
        end else begin
            acc <= en ? (phase == '0 ? (DW+SH)'(pixIn) : sum) : clr ? '0 : acc;
            if (load)
                pixOut <= sum[DW+SH-1:SH];
        end
endmodule

// File: rtl/ccd_decim_4x.sv
// ccd_decim_4x: 4:1 horizontal box average and 1-in-4 line keep for the PiP path;
// every kept line yields exactly OUT_W strobes.
module ccd_decim_4x
    import ccd_pip_pkg::*;
#(
    parameter int IN_W      = CCD_IN_W,
    parameter int HDEC_LOG2 = 2,
    parameter int VDEC_LOG2 = 2,
    parameter int OUT_W     = IN_W >> HDEC_LOG2,
    parameter int DW        = CCD_DW
) (
    input  logic          iCCD_PIXCLK,
    input  logic          iRST,
    input  logic [DW-1:0] iCCD_R,
    input  logic [DW-1:0] iCCD_G,
    input  logic [DW-1:0] iCCD_B,
    input  logic          iCCD_DVAL,
    input  logic          iCCD_FVAL,
    output logic [DW-1:0] oCCD_R,
    output logic [DW-1:0] oCCD_G,
    output logic [DW-1:0] oCCD_B,
    output logic          oCCD_DVAL,
    output logic          oLINE_ERR
);
    localparam logic [10:0] IN_WV  = 11'(IN_W);
    localparam logic [8:0]  OUT_WV = 9'(OUT_W);

    logic                 fvalD, dvalD;
    logic [9:0]           lineCnt, line;
    logic [10:0]          colCnt, cc;
    logic [8:0]           outCnt, oc;
    logic [HDEC_LOG2-1:0] phase, ph;
    logic                 dv, fvalRise, fvalFall, lineEnd, kept, emit, clr;

    // Pixels only count inside the frame, so an FVAL drop also ends the line as an abort
    assign dv       = iCCD_DVAL & iCCD_FVAL;
    assign fvalRise = iCCD_FVAL & ~fvalD;
    assign fvalFall = ~iCCD_FVAL & fvalD;
    assign lineEnd  = dvalD & ~dv;
    assign clr      = fvalRise | fvalFall;

    // A pixel arriving with the FVAL rising edge sees freshly cleared counters
    assign ph   = fvalRise ? '0 : phase;
    assign line = fvalRise ? '0 : lineCnt;
    assign cc   = fvalRise ? '0 : colCnt;
    assign oc   = fvalRise ? '0 : outCnt;
    assign kept = line[VDEC_LOG2-1:0] == '0;
    assign emit = dv & (ph == '1) & kept & (oc < OUT_WV);

    always_ff @(posedge iCCD_PIXCLK or posedge iRST)
        if (iRST) begin
            fvalD     <= 1'b0;
            dvalD     <= 1'b0;
            lineCnt   <= '0;
            colCnt    <= '0;
            outCnt    <= '0;
            phase     <= '0;
            oCCD_DVAL <= 1'b0;
            oLINE_ERR <= 1'b0;
        end else begin
            fvalD     <= iCCD_FVAL;
            dvalD     <= dv;
            oCCD_DVAL <= emit;
            oLINE_ERR <= lineEnd & ~fvalFall & (colCnt != IN_WV);
            if (fvalFall) begin
                phase  <= '0;
                colCnt <= '0;
                outCnt <= '0;
            end else if (lineEnd) begin
                lineCnt <= lineCnt + 10'd1;
                phase   <= '0;
                colCnt  <= '0;
                outCnt  <= '0;
            end else if (dv) begin
                lineCnt <= line;
                phase   <= ph + 1'b1;
                colCnt  <= cc + 11'(cc != '1);
                outCnt  <= oc + 9'(emit);
            end else if (fvalRise) begin
                lineCnt <= '0;
                phase   <= '0;
                colCnt  <= '0;
                outCnt  <= '0;
            end
        end

    decim_acc #(.DW(DW), .SH(HDEC_LOG2)) accR (
        .clk(iCCD_PIXCLK), .rst(iRST), .en(dv), .clr(clr), .load(emit),
        .phase(ph), .pixIn(iCCD_R), .pixOut(oCCD_R)
    );

    decim_acc #(.DW(DW), .SH(HDEC_LOG2)) accG (
        .clk(iCCD_PIXCLK), .rst(iRST), .en(dv), .clr(clr), .load(emit),
        .phase(ph), .pixIn(iCCD_G), .pixOut(oCCD_G)
    );

    decim_acc #(.DW(DW), .SH(HDEC_LOG2)) accB (
        .clk(iCCD_PIXCLK), .rst(iRST), .en(dv), .clr(clr), .load(emit),
        .phase(ph), .pixIn(iCCD_B), .pixOut(oCCD_B)
    );
endmodule

// File: tb/tb_ccd_decim_4x.sv
// tb_ccd_decim_4x: directed checks of averaging, line keep, line-length errors and aborts
module tb_ccd_decim_4x;
    import ccd_pip_pkg::*;

    logic       clk = 1'b0;
    logic       rst, fval, dval;
    rgb_t       pix;
    logic [9:0] oR, oG, oB;
    logic       oDval, oErr;

    int   checks = 0, failures = 0;
    int   tcyc = 0, fallCyc = 0, lineStart = 0, mode = 0;
    int   strobes = 0, errs = 0, errAt = -1, firstAt = -1;
    bit   valOn = 1'b0;
    rgb_t first0, first1;

    always #5 clk = ~clk;

    ccd_decim_4x dut (
        .iCCD_PIXCLK(clk), .iRST(rst),
        .iCCD_R(pix.r), .iCCD_G(pix.g), .iCCD_B(pix.b),
        .iCCD_DVAL(dval), .iCCD_FVAL(fval),
        .oCCD_R(oR), .oCCD_G(oG), .oCCD_B(oB),
        .oCCD_DVAL(oDval), .oLINE_ERR(oErr)
    );

    function automatic rgb_t pixOf(int m, int c);
        rgb_t p;
        logic [10:0] cv;
        cv = 11'(c);
        if (m == 0) begin
            p.r = 10'd400; p.g = 10'd400; p.b = 10'd400;
        end else if (m == 1) begin
            p.r = cv[9:0]; p.g = 10'd0; p.b = ~cv[9:0];
        end else begin
            p.r = 10'd1023; p.g = 10'd1023; p.b = 10'd1023;
        end
        return p;
    endfunction

    function automatic rgb_t expOf(int m, int g);
        int r = 0, gr = 0, b = 0;
        rgb_t p, e;
        for (int k = 0; k < 4; k++) begin
            p = pixOf(m, 4*g + k);
            r += int'(p.r); gr += int'(p.g); b += int'(p.b);
        end
        e.r = 10'(r >> 2); e.g = 10'(gr >> 2); e.b = 10'(b >> 2);
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
        tcyc++;
        if (oDval) begin
            if (firstAt < 0) firstAt = tcyc - lineStart - 1;
            if (strobes == 0) first0 = {oR, oG, oB};
            if (strobes == 1) first1 = {oR, oG, oB};
            if (valOn) chk("pix_value", int'({oR, oG, oB}), int'(expOf(mode, strobes)));
            strobes++;
        end
        if (oErr) begin
            errs++;
            errAt = tcyc - fallCyc;
        end
    endtask

    task automatic clearCounts();
        strobes = 0; errs = 0; errAt = -1; firstAt = -1;
    endtask

    task automatic pixels(input int n, input int m, input bit check);
        mode = m; valOn = check;
        clearCounts();
        lineStart = tcyc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fval = 1'b1; dval = 1'b1; pix = pixOf(m, i);
            sample();
        end
    endtask

    task automatic idle(input int n, input bit f);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dval) fallCyc = tcyc + 1;
            dval = 1'b0; fval = f; pix = '0;
            sample();
        end
    endtask

    task automatic newFrame();
        idle(3, 1'b0);
        idle(2, 1'b1);
    endtask

    initial begin
        rst = 1'b1; fval = 1'b0; dval = 1'b0; pix = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dval", int'(oDval), 0);
        chk("reset_rgb", int'({oR, oG, oB}), 0);
        chk("reset_err", int'(oErr), 0);
        @(negedge clk);
        rst = 1'b0;

        // Constant frame: only lines 0 and 4 are kept
        newFrame();
        for (int l = 0; l < 8; l++) begin
            pixels(1280, 0, 1'b1);
            idle(4, 1'b1);
            chk("const_strobes", strobes, (l % 4 == 0) ? 320 : 0);
            chk("const_err", errs, 0);
        end

        // Ramp with DVAL rising in the same cycle as FVAL
        idle(3, 1'b0);
        pixels(1280, 1, 1'b1);
        idle(4, 1'b1);
        chk("ramp_strobes", strobes, 320);
        chk("ramp_latency", firstAt, 3);
        chk("ramp_first", int'(first0.r), 1);
        chk("ramp_second", int'(first1.r), 5);
        chk("ramp_err", errs, 0);

        newFrame();
        pixels(1280, 2, 1'b1);
        idle(4, 1'b1);
        chk("sat_strobes", strobes, 320);
        chk("sat_value", int'(first0), int'({10'd1023, 10'd1023, 10'd1023}));
        chk("sat_err", errs, 0);

        newFrame();
        pixels(1278, 0, 1'b1);
        idle(4, 1'b1);
        chk("short_strobes", strobes, 319);
        chk("short_err_count", errs, 1);
        chk("short_err_time", errAt, 0);

        newFrame();
        pixels(1290, 0, 1'b1);
        idle(4, 1'b1);
        chk("long_strobes", strobes, 320);
        chk("long_err_count", errs, 1);
        chk("long_err_time", errAt, 0);

        // Async reset in the middle of line 0
        newFrame();
        pixels(700, 0, 1'b1);
        chk("mid_strobes", strobes, 175);
        chk("pre_rst_r", int'(oR), 400);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_dval", int'(oDval), 0);
        chk("rst_async_rgb", int'({oR, oG, oB}), 0);
        dval = 1'b0; fval = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        newFrame();
        pixels(1280, 0, 1'b1);
        idle(4, 1'b1);
        chk("post_rst_strobes", strobes, 320);
        chk("post_rst_err", errs, 0);

        // FVAL drops at pixel 500 while DVAL lingers briefly
        newFrame();
        pixels(500, 0, 1'b1);
        chk("abort_pre_strobes", strobes, 125);
        clearCounts();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            fval = 1'b0; dval = 1'b1; pix = pixOf(0, 500 + i);
            sample();
        end
        idle(6, 1'b0);
        chk("abort_strobes", strobes, 0);
        chk("abort_err", errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ccd_decim_4x.md
Name: ccd_decim_4x

Overview:
- Upstream neighbour of the 4X column mirror stage in the CCD picture-in-picture path.
- Takes full-resolution RGB pixels from the CCD capture and Bayer-to-RGB path.
- Box-averages each group of 4 horizontal pixels and keeps 1 line in 4.
- Emits exactly OUT_W pixels per kept line, so the downstream 320-entry line stack always wraps on a line boundary.

Parameters:
- IN_W, 1280: active input pixels per line.
- HDEC_LOG2, 2: log2 of horizontal decimation factor (4:1).
- VDEC_LOG2, 2: log2 of vertical decimation factor (keep 1 of 4 lines).
- OUT_W, IN_W>>HDEC_LOG2 (320): output pixels per kept line.
- DW, 10: colour channel width.

Ports:
- iCCD_PIXCLK  in   1   pixel clock; the only clock.
- iRST         in   1   asynchronous, active-high reset.
- iCCD_R       in   DW  red pixel, valid when iCCD_DVAL=1.
- iCCD_G       in   DW  green pixel.
- iCCD_B       in   DW  blue pixel.
- iCCD_DVAL    in   1   pixel valid; high for the duration of each line's active pixels.
- iCCD_FVAL    in   1   frame valid; rising edge marks start of frame.
- oCCD_R       out  DW  averaged red.
- oCCD_G       out  DW  averaged green.
- oCCD_B       out  DW  averaged blue.
- oCCD_DVAL    out  1   single-cycle strobe per output pixel.
- oLINE_ERR    out  1   one-cycle pulse when a line ends with input count != IN_W.

Behaviour:
- Reset (async, iRST=1): all outputs 0; all counters, accumulators and edge registers 0.
- The iCCD_FVAL rising edge clears the line counter, column counter, phase and accumulators. The first line after that edge is line 0.
- Falling edge of iCCD_FVAL mid-line: abort the line. Clear phase, accumulators and column counter; emit no partial pixel and no oLINE_ERR.
- Per-channel accumulator is DW+HDEC_LOG2 (12) bits, unsigned.
- Phase counter is HDEC_LOG2 bits and advances only on iCCD_DVAL=1:
  - Phase 0: acc <= in.
  - Phases 1..2: acc <= acc + in.
  - Phase 3: registered output <= (acc + in) >> HDEC_LOG2, truncating with no rounding.
- Output timing:
  - oCCD_DVAL=1 on the cycle after the 4th pixel of a group, only on kept lines and only while out_cnt < OUT_W.
  - Latency is 1 clock from the 4th input pixel to output.
  - oCCD_R/G/B hold their last value when oCCD_DVAL=0.
- Kept line: line_cnt[VDEC_LOG2-1:0]==0. On discarded lines, accumulators may run but oCCD_DVAL stays 0.
- Column counter (11 bits) counts DVAL pixels. out_cnt (9 bits) counts emitted pixels and saturates at OUT_W; pixels past IN_W are ignored.
- Line end is the iCCD_DVAL falling edge, detected with a 1-cycle registered DVAL. On line end:
  - Line counter increments, wrapping at its width (10 bits).
  - Phase, column counter and out_cnt clear.
  - An incomplete trailing group is discarded.
  - oLINE_ERR pulses for 1 cycle if the column count != IN_W (both short and long lines).
- DVAL gaps inside a line are not allowed. Any low cycle ends the line.
- A line end coinciding with an FVAL falling edge is treated as an abort; oLINE_ERR does not pulse.
- A DVAL rising edge in the same cycle as an FVAL rising edge: that pixel belongs to line 0, phase 0.
- There is no back-pressure: the downstream stage accepts every strobe.

Decomposition:
- Shared package ccd_pip_pkg holds:
  - Constants: CCD_DW=10, CCD_IN_W=1280, PIP_OUT_W=320.
  - A typedef rgb_t containing r, g and b, each CCD_DW bits.
- One sub-module, decim_acc: a single-channel accumulator with phase-3 shift output, instantiated three times (R, G, B).
- Counters, edge detection and line-keep logic stay in the top level.

Test Plan:
- Constant frame, R=G=B=400, 1280-pixel lines, 8 lines:
  - Lines 0 and 4 each produce exactly 320 strobes of 400.
  - Lines 1-3 and 5-7 produce none.
  - oLINE_ERR stays 0.
- Ramp R=column[9:0] on line 0: pixels 0..3 give output 1 (sum 6, >>2). Pixels 4..7 give 5. Strobe arrives 1 clock after pixel 3.
- Saturation, all channels 1023: output 1023, no wrap in the 12-bit accumulator.
- Short line of 1278 pixels:
  - 319 strobes, trailing 2-pixel group dropped.
  - oLINE_ERR pulses once on the cycle after DVAL falls.
- Long line of 1290 pixels: exactly 320 strobes, then oLINE_ERR pulses.
- Mid-operation disturbances:
  - Assert iRST at pixel 700 of line 0: outputs go to 0 immediately.
  - After release, a new FVAL edge starts line 0 cleanly.
  - Drop FVAL at pixel 500 of a separate run: no further strobes and no oLINE_ERR.
